sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; next generation of the MAC data/ctrl buffers.

---
 rtl/lmac_fifo_pkg.sv | 33 +++
 rtl/sync_fifo_ram.sv | 30 +++
 rtl/sync_fifo_param.sv | 112 +++++++++++
 tb/tb_sync_fifo_param.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/lmac_fifo_pkg.sv
// Shared helpers for the LMAC FIFO family: wrap-bit pointer compares,
// configuration range checks and the error-flag bit encoding.
package lmac_fifo_pkg;

  localparam int FIFO_ERR_W   = 2;
  localparam int FIFO_ERR_OVF = 0;
  localparam int FIFO_ERR_UDF = 1;

  typedef logic [FIFO_ERR_W-1:0] fifo_err_t;

  // Pointers are ptr_w+1 bits wide; the extra MSB is the wrap bit.
  function automatic logic ptr_empty(input logic [31:0] wp, input logic [31:0] rp,
                                     input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << (ptr_w + 1)) - 32'd1;
    return ((wp ^ rp) & mask) == 32'd0;
  endfunction

  function automatic logic ptr_full(input logic [31:0] wp, input logic [31:0] rp,
                                    input int unsigned ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << (ptr_w + 1)) - 32'd1;
    return ((wp ^ rp) & mask) == (32'd1 << ptr_w);
  endfunction

  function automatic bit fifo_cfg_ok(input int depth, input int ptr_w,
                                     input int afull_th, input int aempty_th);
    return (depth >= 4) && (depth == (1 << ptr_w)) &&
           (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x WIDTH storage with one write port and one registered read port.
// Only the read-data register is reset; the array itself is not.
module sync_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR   = 4
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             we,
  input  logic [PTR-1:0]   waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [PTR-1:0]   raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Same-address write and read (full FIFO) returns the old word.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_)  rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with exact occupancy, almost-full/empty flags and flush.
// Define SYNC_FIFO_ERR_EN to build the sticky ovf/udf error flags.
module sync_fifo_param
  import lmac_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR       = 4,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             flush,
  input  logic             wren,
  input  logic [WIDTH-1:0] datain,
  output logic             wrfull,
  output logic             wralmfull,
  input  logic             rden,
  output logic [WIDTH-1:0] dataout,
  output logic             dataout_valid,
  output logic             rdempty,
  output logic             rdalmempty,
  output logic [PTR:0]     usedw,
  output logic             ovf,
  output logic             udf
);

  if (!fifo_cfg_ok(DEPTH, PTR, AFULL_TH, AEMPTY_TH)) begin : g_cfg_err
    $error("sync_fifo_param: illegal DEPTH/PTR/threshold combination");
  end

  localparam logic [PTR:0] AFULL_V  = (PTR+1)'(AFULL_TH);
  localparam logic [PTR:0] AEMPTY_V = (PTR+1)'(AEMPTY_TH);

  logic [PTR:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, usedw_n;
  logic         wr_acc, rd_acc;

  assign rd_acc   = rden & ~rdempty;
  assign wr_acc   = wren & (~wrfull | rd_acc);
  assign wr_ptr_n = wr_ptr + {{PTR{1'b0}}, wr_acc};
  assign rd_ptr_n = rd_ptr + {{PTR{1'b0}}, rd_acc};
  assign usedw_n  = usedw + {{PTR{1'b0}}, wr_acc} - {{PTR{1'b0}}, rd_acc};

  // Flags are registered from next-state values so they agree with usedw every cycle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      usedw         <= '0;
      wrfull        <= 1'b0;
      wralmfull     <= 1'b0;
      rdempty       <= 1'b1;
      rdalmempty    <= 1'b1;
      dataout_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      usedw         <= '0;
      wrfull        <= 1'b0;
      wralmfull     <= 1'b0;
      rdempty       <= 1'b1;
      rdalmempty    <= 1'b1;
      dataout_valid <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_n;
      rd_ptr        <= rd_ptr_n;
      usedw         <= usedw_n;
      wrfull        <= ptr_full(32'(wr_ptr_n), 32'(rd_ptr_n), PTR);
      rdempty       <= ptr_empty(32'(wr_ptr_n), 32'(rd_ptr_n), PTR);
      wralmfull     <= (usedw_n >= AFULL_V);
      rdalmempty    <= (usedw_n <= AEMPTY_V);
      dataout_valid <= rd_acc;
    end
  end

  sync_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR   (PTR)
  ) u_ram (
    .clk    (clk),
    .reset_ (reset_),
    .we     (wr_acc & ~flush & reset_),
    .waddr  (wr_ptr[PTR-1:0]),
    .wdata  (datain),
    .re     (rd_acc & ~flush),
    .raddr  (rd_ptr[PTR-1:0]),
    .rdata  (dataout)
  );

`ifdef SYNC_FIFO_ERR_EN
  fifo_err_t err_q;

  // Sticky until reset; a flush cycle ignores wren/rden so it cannot set them.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      err_q <= '0;
    end else if (!flush) begin
      if (wren & wrfull & ~rd_acc) err_q[FIFO_ERR_OVF] <= 1'b1;
      if (rden & rdempty)          err_q[FIFO_ERR_UDF] <= 1'b1;
    end
  end

  assign ovf = err_q[FIFO_ERR_OVF];
  assign udf = err_q[FIFO_ERR_UDF];
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Randomised and directed bench for sync_fifo_param against a queue-based model.
module tb_sync_fifo_param;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int PTR       = 4;
  localparam int AFULL_TH  = DEPTH - 2;
  localparam int AEMPTY_TH = 2;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset_, flush, wren, rden;
  logic [WIDTH-1:0] datain, dataout;
  logic             wrfull, wralmfull, dataout_valid, rdempty, rdalmempty, ovf, udf;
  logic [PTR:0]     usedw;

  sync_fifo_param #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .PTR(PTR), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .clk(clk), .reset_(reset_), .flush(flush), .wren(wren), .datain(datain),
    .wrfull(wrfull), .wralmfull(wralmfull), .rden(rden), .dataout(dataout),
    .dataout_valid(dataout_valid), .rdempty(rdempty), .rdalmempty(rdalmempty),
    .usedw(usedw), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_valid, m_ovf, m_udf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else             n_pass++;
  endtask

  task automatic model_reset();
    q.delete();
    m_dout  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    chk("usedw",         32'(usedw),         32'(n));
    chk("wrfull",        32'(wrfull),        32'(n == DEPTH));
    chk("wralmfull",     32'(wralmfull),     32'(n >= AFULL_TH));
    chk("rdempty",       32'(rdempty),       32'(n == 0));
    chk("rdalmempty",    32'(rdalmempty),    32'(n <= AEMPTY_TH));
    chk("dataout",       32'(dataout),       32'(m_dout));
    chk("dataout_valid", 32'(dataout_valid), 32'(m_valid));
    chk("ovf",           32'(ovf),           32'(m_ovf));
    chk("udf",           32'(udf),           32'(m_udf));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input bit wr, input bit rd, input bit fl, input logic [WIDTH-1:0] d);
    bit full, empty, rd_ok, wr_ok;
    wren = wr; rden = rd; flush = fl; datain = d;
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_valid = 1'b0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      rd_ok = rd && !empty;
      wr_ok = wr && (!full || rd_ok);
      if (ERR_EN && wr && full && !rd_ok) m_ovf = 1'b1;
      if (ERR_EN && rd && empty)          m_udf = 1'b1;
      m_valid = rd_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_ = 1'b0; flush = 1'b0; wren = 1'b0; rden = 1'b0; datain = '0;
    model_reset();
    #12;
    check_all();
    @(posedge clk); #1;
    reset_ = 1'b1;

    // Fill with 0x01..0x10, then drain plus one extra read.
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(i));
    chk("fill_wrfull", 32'(wrfull), 32'd1);
    for (int i = 0; i <= DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0);
    chk("drain_hold", 32'(dataout), 32'h10);
    chk("drain_extra_valid", 32'(dataout_valid), 32'd0);

    // Full with simultaneous write and read.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, WIDTH'($urandom_range(0, 255)));
    step(1'b1, 1'b1, 1'b0, 8'hAA);
    chk("full_wr_rd_usedw", 32'(usedw), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b0, '0);
    chk("aa_last", 32'(dataout), 32'hAA);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, WIDTH'($urandom_range(0, 255)));
    step(1'b1, 1'b0, 1'b0, 8'h77);
    step(1'b0, 1'b0, 1'b1, '0);

    // Empty with simultaneous write and read: no bypass.
    step(1'b1, 1'b1, 1'b0, 8'h55);
    chk("empty_wr_rd_valid", 32'(dataout_valid), 32'd0);
    chk("empty_wr_rd_usedw", 32'(usedw), 32'd1);
    step(1'b0, 1'b1, 1'b0, '0);
    chk("empty_next_rd", 32'(dataout), 32'h55);

    // Interleaved traffic across two pointer wraps.
    step(1'b1, 1'b0, 1'b0, WIDTH'($urandom_range(0, 255)));
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b0, WIDTH'($urandom_range(0, 255)));
    step(1'b0, 1'b1, 1'b0, '0);

    // Flush at usedw=9 with a write pending.
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, WIDTH'(8'hC0 + i));
    step(1'b1, 1'b0, 1'b1, 8'hEE);
    chk("flush_usedw", 32'(usedw), 32'd0);
    chk("flush_rdempty", 32'(rdempty), 32'd1);

    // Random traffic with phase-varying bias and occasional flushes.
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = ((i / 50) % 2 == 0) ? 70 : 30;
      step(($urandom_range(0, 99) < bias), ($urandom_range(0, 99) < (100 - bias)),
           ($urandom_range(0, 59) == 0), WIDTH'($urandom_range(0, 255)));
    end

    // Asynchronous reset in the middle of a burst.
    for (int i = 0; i < 6; i++) step(1'b1, (i > 2), 1'b0, WIDTH'($urandom_range(0, 255)));
    #3;
    reset_ = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("async_rst_dout", 32'(dataout), 32'd0);
    wren = 1'b0; rden = 1'b0;
    @(posedge clk); #1;
    reset_ = 1'b1;
    for (int i = 0; i < 20; i++)
      step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 1'b0, WIDTH'($urandom_range(0, 255)));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
